// File: rtl/data_cache_wb_if.sv
// rtl/data_cache_wb_if.sv - core request bus and backing-memory beat bus for data_cache_wb
interface data_cache_wb_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask, mem_rdata, mem_ack,
    output read_data, clk_stall, misaligned, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, write_data, memwrite, memread, sign_mask, mem_rdata, mem_ack,
    input  read_data, clk_stall, misaligned, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_wb.sv
// rtl/data_cache_wb.sv - direct-mapped write-back data cache; optional LED MMIO via DATA_CACHE_LED_MMIO_EN
module data_cache_wb #(
  parameter int          NUM_LINES      = 16,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] LED_ADDR       = 32'h0000_2000
) (
  input  logic             clk,
  input  logic             reset,
  data_cache_wb_if.slave   bus,
  output logic [7:0]       led
);
  localparam int WB    = $clog2(WORDS_PER_LINE);
  localparam int LB    = $clog2(NUM_LINES);
  localparam int WI_W  = (WB > 0) ? WB : 1;
  localparam int TAG_W = 32 - 2 - WB - LB;

  typedef enum logic [1:0] {IDLE, COMPARE, EVICT, REFILL} state_t;
  state_t state;

  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [3:0]           req_mask;
  logic                 req_write;
  logic [WI_W-1:0]      beat;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_arr [NUM_LINES];
  logic [31:0]          data_arr [NUM_LINES][WORDS_PER_LINE];

  logic [31:0] read_data, mem_addr, mem_wdata;
  logic        misaligned, mem_req, mem_we;

  logic [1:0]       offset;
  logic [WI_W-1:0]  widx;
  logic [LB-1:0]    line;
  logic [TAG_W-1:0] tag;
  logic             is_byte, is_half, mis, hit, last_beat, led_sel;
  logic [31:0]      cur_word, shifted, load_val, wsh, merged;
  logic [3:0]       be;

  assign offset    = req_addr[1:0];
  assign widx      = WI_W'((req_addr >> 2) & 32'(WORDS_PER_LINE - 1));
  assign line      = LB'(req_addr >> (2 + WB));
  assign tag       = req_addr[31 -: TAG_W];
  assign is_byte   = (req_mask[2:0] == 3'b001);
  assign is_half   = (req_mask[2:0] == 3'b011);
  assign mis       = (is_half && offset[0]) || (!is_byte && !is_half && offset != 2'd0);
  assign hit       = valid[line] && (tag_arr[line] == tag);
  assign last_beat = (beat == WI_W'(WORDS_PER_LINE - 1));
  assign cur_word  = data_arr[line][widx];

`ifdef DATA_CACHE_LED_MMIO_EN
  assign led_sel = ({req_addr[31:2], 2'b00} == LED_ADDR);

  // LED register is written by a store to LED_ADDR while in COMPARE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) led <= 8'h00;
    else if (state == COMPARE && led_sel && req_write && !mis) led <= req_wdata[7:0];
  end
`else
  logic unused_led_addr;
  assign unused_led_addr = ^LED_ADDR;
  assign led_sel = 1'b0;
  assign led     = 8'h00;
`endif

  function automatic logic [31:0] beat_addr(input logic [TAG_W-1:0] t, input logic [LB-1:0] l,
                                            input logic [WI_W-1:0] b);
    return (32'(t) << (2 + WB + LB)) | (32'(l) << (2 + WB)) | (32'(b) << 2);
  endfunction

  // Load extraction and store byte merge for the addressed word
  always_comb begin
    shifted  = cur_word >> {offset, 3'b000};
    load_val = cur_word;
    if (is_byte)      load_val = {{24{req_mask[3] & shifted[7]}}, shifted[7:0]};
    else if (is_half) load_val = {{16{req_mask[3] & shifted[15]}}, shifted[15:0]};
    be = 4'b1111;
    if (is_byte)      be = 4'b0001 << offset;
    else if (is_half) be = 4'b0011 << offset;
    wsh    = req_wdata << {offset, 3'b000};
    merged = cur_word;
    for (int i = 0; i < 4; i++) merged[i*8 +: 8] = be[i] ? wsh[i*8 +: 8] : cur_word[i*8 +: 8];
  end

  // Data and tag arrays carry no reset; only valid/dirty decide what is live
  always_ff @(posedge clk) begin
    if (state == COMPARE && req_write && hit && !mis && !led_sel) data_arr[line][widx] <= merged;
    if (state == REFILL && mem_req && bus.mem_ack) begin
      data_arr[line][beat] <= bus.mem_rdata;
      if (last_beat) tag_arr[line] <= tag;
    end
  end

  // Request FSM: accept, compare, write back a dirty victim, refill, re-compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_mask   <= '0;
      req_write  <= 1'b0;
      beat       <= '0;
      read_data  <= '0;
      misaligned <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.memread || bus.memwrite) begin
            req_addr  <= bus.addr;
            req_wdata <= bus.write_data;
            req_mask  <= bus.sign_mask;
            req_write <= bus.memwrite;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (mis) begin
            read_data  <= '0;
            misaligned <= 1'b1;
            state      <= IDLE;
          end else if (led_sel) begin
            if (!req_write) read_data <= {24'b0, led};
            state <= IDLE;
          end else if (hit) begin
            if (req_write) dirty[line] <= 1'b1;
            else           read_data   <= load_val;
            state <= IDLE;
          end else begin
            beat  <= '0;
            state <= (valid[line] && dirty[line]) ? EVICT : REFILL;
          end
        end
        EVICT: begin
          if (mem_req) begin
            if (bus.mem_ack) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              if (last_beat) begin
                dirty[line] <= 1'b0;
                beat        <= '0;
                state       <= REFILL;
              end else begin
                beat <= beat + WI_W'(1);
              end
            end
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= beat_addr(tag_arr[line], line, beat);
            mem_wdata <= data_arr[line][beat];
          end
        end
        REFILL: begin
          if (mem_req) begin
            if (bus.mem_ack) begin
              mem_req <= 1'b0;
              if (last_beat) begin
                valid[line] <= 1'b1;
                dirty[line] <= 1'b0;
                beat        <= '0;
                state       <= COMPARE;
              end else begin
                beat <= beat + WI_W'(1);
              end
            end
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= beat_addr(tag, line, beat);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_data  = read_data;
  assign bus.clk_stall  = (state != IDLE);
  assign bus.misaligned = misaligned;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
endmodule
